// File: rtl/pipe_addr_tree.sv
// Pipelined binary adder tree with an accumulating, optionally saturating output stage.
// Build option: define ADDR_TREE_SAT_EN for saturating accumulation and a sticky ovf flag.
module pipe_addr_tree #(
  parameter int unsigned N_IN        = 8,
  parameter int unsigned PREC        = 7,
  parameter int unsigned PIPE_STRIDE = 2,
  parameter int unsigned ACC_W       = PREC + $clog2(N_IN) + 4
) (
  input  logic                    CLK,
  input  logic                    RESET_N,
  input  logic                    in_valid,
  input  logic [N_IN*PREC-1:0]    in,
  input  logic                    hold,
  input  logic                    acc_en,
  input  logic                    acc_clr,
  output logic                    out_valid,
  output logic signed [ACC_W-1:0] out,
  output logic                    ovf
);

  localparam int unsigned LVLS = $clog2(N_IN);
  localparam int unsigned NREG = (LVLS + PIPE_STRIDE - 1) / PIPE_STRIDE;
  localparam int unsigned RW   = PREC + LVLS;

  // Sideband pipe: bit 0 is the input rank, bit NREG is the rank at the tree root.
  logic [NREG:0] vld_q;
  logic [NREG:0] ae_q;
  logic [NREG:0] ac_q;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      vld_q <= '0;
      ae_q  <= '0;
      ac_q  <= '0;
    end else if (!hold) begin
      vld_q <= {vld_q[NREG-1:0], in_valid};
      ae_q  <= {ae_q[NREG-1:0], in_valid & acc_en};
      ac_q  <= {ac_q[NREG-1:0], in_valid & acc_clr};
    end
  end

  // Level k holds N_IN>>k partial sums of PREC+k bits each; level 0 is the input rank.
  for (genvar k = 0; k <= LVLS; k++) begin : g_lvl
    localparam int unsigned W  = PREC + k;
    localparam int unsigned NN = N_IN >> k;

    logic [NN*W-1:0] node;

    if (k == 0) begin : g_in
      always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
          node <= '0;
        end else if (!hold && in_valid) begin
          node <= in;
        end
      end
    end else begin : g_add
      localparam int unsigned PW = W - 1;
      localparam int unsigned R  = (k + PIPE_STRIDE - 1) / PIPE_STRIDE;

      logic [NN*W-1:0] sum_c;

      always_comb begin
        sum_c = '0;
        for (int unsigned j = 0; j < NN; j++) begin
          sum_c[j*W +: W] = W'($signed(g_lvl[k-1].node[(2*j)*PW +: PW]))
                          + W'($signed(g_lvl[k-1].node[(2*j+1)*PW +: PW]));
        end
      end

      // A rank sits after every PIPE_STRIDE levels and always at the root.
      if ((k % PIPE_STRIDE == 0) || (k == LVLS)) begin : g_reg
        always_ff @(posedge CLK or negedge RESET_N) begin
          if (!RESET_N) begin
            node <= '0;
          end else if (!hold && vld_q[R-1]) begin
            node <= sum_c;
          end
        end
      end else begin : g_comb
        assign node = sum_c;
      end
    end
  end

  logic signed [RW-1:0]    root_c;
  logic signed [ACC_W-1:0] root_ext_c;
  logic signed [ACC_W-1:0] acc_c;
  logic                    acc_ovf_c;

  assign root_c     = $signed(g_lvl[LVLS].node);
  assign root_ext_c = ACC_W'(root_c);

`ifdef ADDR_TREE_SAT_EN
  localparam int unsigned SW = ACC_W + 1;
  localparam logic signed [ACC_W-1:0] MAX_V = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MIN_V = {1'b1, {(ACC_W-1){1'b0}}};

  logic signed [SW-1:0] acc_sum_c;

  // One guard bit: overflow when the two top bits disagree; clamp toward the sign of the guard.
  assign acc_sum_c = SW'(out) + SW'(root_ext_c);
  assign acc_ovf_c = acc_sum_c[ACC_W] ^ acc_sum_c[ACC_W-1];

  always_comb begin
    acc_c = acc_sum_c[ACC_W-1:0];
    if (acc_ovf_c) begin
      acc_c = acc_sum_c[ACC_W] ? MIN_V : MAX_V;
    end
  end
`else
  assign acc_c     = out + root_ext_c;
  assign acc_ovf_c = 1'b0;
`endif

  // Output stage: load or accumulate the root beat, track sticky overflow.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      out       <= '0;
      out_valid <= 1'b0;
      ovf       <= 1'b0;
    end else if (!hold) begin
      out_valid <= vld_q[NREG];
      if (vld_q[NREG]) begin
        if (!ae_q[NREG] || ac_q[NREG]) begin
          out <= root_ext_c;
        end else begin
          out <= acc_c;
        end
        if (ac_q[NREG]) begin
          ovf <= 1'b0;
        end else if (ae_q[NREG] && acc_ovf_c) begin
          ovf <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pipe_addr_tree.sv
// Scoreboard bench for pipe_addr_tree (N_IN=8, PREC=7, PIPE_STRIDE=2, ACC_W=12).
module tb_pipe_addr_tree;

  localparam int unsigned N   = 8;
  localparam int unsigned P   = 7;
  localparam int unsigned AW  = 12;
  localparam int unsigned LAT = 3;

  typedef struct packed {
    logic signed [AW-1:0] val;
    logic                 ovf;
  } exp_t;

  logic                 CLK;
  logic                 RESET_N;
  logic                 in_valid;
  logic [N*P-1:0]       in;
  logic                 hold;
  logic                 acc_en;
  logic                 acc_clr;
  logic                 out_valid;
  logic signed [AW-1:0] out;
  logic                 ovf;

  exp_t exp_q[$];
  int   m_acc;
  bit   m_ovf;
  int   n_chk;
  int   n_fail;

  pipe_addr_tree #(
    .N_IN(N), .PREC(P), .PIPE_STRIDE(2), .ACC_W(AW)
  ) dut (
    .CLK(CLK), .RESET_N(RESET_N), .in_valid(in_valid), .in(in), .hold(hold),
    .acc_en(acc_en), .acc_clr(acc_clr), .out_valid(out_valid), .out(out), .ovf(ovf)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [N*P-1:0] fill(input int x);
    logic [N*P-1:0] r;
    for (int i = 0; i < int'(N); i++) r[P*i +: P] = P'(x);
    return r;
  endfunction

  function automatic logic [N*P-1:0] alt_pm1();
    logic [N*P-1:0] r;
    for (int i = 0; i < int'(N); i++) r[P*i +: P] = (i % 2 == 0) ? P'(1) : P'(-1);
    return r;
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    acc_en   = 1'b0;
    acc_clr  = 1'b0;
    in       = '0;
  endtask

  // Drive one beat and push its expected output via the reference accumulator model.
  task automatic set_beat(input logic [N*P-1:0] v, input bit ae, input bit ac);
    int   root;
    int   s;
    exp_t e;
    root = 0;
    for (int i = 0; i < int'(N); i++) root += int'($signed(v[P*i +: P]));
    if (!ae || ac) begin
      m_acc = root;
    end else begin
      s = m_acc + root;
`ifdef ADDR_TREE_SAT_EN
      if (s > 2047) begin
        m_acc = 2047;
        m_ovf = 1'b1;
      end else if (s < -2048) begin
        m_acc = -2048;
        m_ovf = 1'b1;
      end else begin
        m_acc = s;
      end
`else
      begin
        logic signed [AW-1:0] w;
        w = AW'(s);
        m_acc = int'(w);
      end
`endif
    end
    if (ac) m_ovf = 1'b0;
    e.val = AW'(m_acc);
    e.ovf = m_ovf;
    exp_q.push_back(e);
    in       = v;
    in_valid = 1'b1;
    acc_en   = ae;
    acc_clr  = ac;
  endtask

  task automatic test_reset();
    RESET_N = 1'b0;
    hold    = 1'b0;
    idle();
    step();
    step();
    n_chk++;
    if (out !== '0) begin n_fail++; $display("FAIL reset_out: got %0d, required 0", out); end
    n_chk++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b, required 0", out_valid); end
    n_chk++;
    if (ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b, required 0", ovf); end
    RESET_N = 1'b1;
    step();
    n_chk++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_release_valid: got %b, required 0", out_valid); end
  endtask

  task automatic test_single();
    exp_t e;
    for (int c = 0; c < 6; c++) begin
      if (c == 0) set_beat(fill(63), 1'b0, 1'b0); else idle();
      step();
      n_chk++;
      if (out_valid !== (c == LAT)) begin
        n_fail++; $display("FAIL single_latency c=%0d: out_valid=%b, required %b", c, out_valid, c == LAT);
      end
      if (out_valid === 1'b1) begin
        n_chk++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL single_extra: out=%0d with empty scoreboard", out); end
        else begin
          e = exp_q.pop_front();
          if (out !== e.val || ovf !== e.ovf) begin
            n_fail++; $display("FAIL single_data: out=%0d ovf=%b, required %0d %b", out, ovf, $signed(e.val), e.ovf);
          end
        end
      end
    end
    n_chk++;
    if (out !== 12'sd504) begin n_fail++; $display("FAIL single_hold_value: out=%0d, required 504", out); end
    n_chk++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL single_drain: %0d beats missing, required 0", exp_q.size()); end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    for (int c = 0; c < 8; c++) begin
      if (c == 0) set_beat(fill(-64), 1'b0, 1'b0);
      else if (c == 1) set_beat(alt_pm1(), 1'b0, 1'b0);
      else idle();
      step();
      n_chk++;
      if (out_valid !== (c == LAT || c == LAT + 1)) begin
        n_fail++; $display("FAIL b2b_valid c=%0d: out_valid=%b, required %b", c, out_valid, c == LAT || c == LAT + 1);
      end
      if (out_valid === 1'b1) begin
        n_chk++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL b2b_extra: out=%0d with empty scoreboard", out); end
        else begin
          e = exp_q.pop_front();
          if (out !== e.val || ovf !== e.ovf) begin
            n_fail++; $display("FAIL b2b_data: out=%0d ovf=%b, required %0d %b", out, ovf, $signed(e.val), e.ovf);
          end
        end
      end
    end
    n_chk++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL b2b_drain: %0d beats missing, required 0", exp_q.size()); end
  endtask

  task automatic test_accum();
    exp_t e;
    for (int c = 0; c < 9; c++) begin
      if (c == 0) set_beat(fill(10), 1'b1, 1'b1);
      else if (c < 3) set_beat(fill(10), 1'b1, 1'b0);
      else idle();
      step();
      n_chk++;
      if (out_valid !== (c >= LAT && c < LAT + 3)) begin
        n_fail++; $display("FAIL accum_valid c=%0d: out_valid=%b, required %b", c, out_valid, c >= LAT && c < LAT + 3);
      end
      if (out_valid === 1'b1) begin
        n_chk++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL accum_extra: out=%0d with empty scoreboard", out); end
        else begin
          e = exp_q.pop_front();
          if (out !== e.val || ovf !== e.ovf) begin
            n_fail++; $display("FAIL accum_data: out=%0d ovf=%b, required %0d %b", out, ovf, $signed(e.val), e.ovf);
          end
        end
      end
    end
    n_chk++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL accum_drain: %0d beats missing, required 0", exp_q.size()); end
  endtask

  task automatic test_hold();
    exp_t e;
    for (int c = 0; c < 11; c++) begin
      if (c == 0) set_beat(fill(5), 1'b0, 1'b0);
      else if (c == 1) set_beat(fill(-3), 1'b0, 1'b0);
      else idle();
      hold = (c >= 2 && c <= 4);
      step();
      n_chk++;
      if (out_valid !== (c == 6 || c == 7)) begin
        n_fail++; $display("FAIL hold_valid c=%0d: out_valid=%b, required %b", c, out_valid, c == 6 || c == 7);
      end
      if (out_valid === 1'b1) begin
        n_chk++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL hold_extra: out=%0d with empty scoreboard", out); end
        else begin
          e = exp_q.pop_front();
          if (out !== e.val || ovf !== e.ovf) begin
            n_fail++; $display("FAIL hold_data: out=%0d ovf=%b, required %0d %b", out, ovf, $signed(e.val), e.ovf);
          end
        end
      end
    end
    hold = 1'b0;
    n_chk++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL hold_drain: %0d beats missing, required 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    set_beat(fill(20), 1'b0, 1'b0);
    step();
    set_beat(fill(30), 1'b0, 1'b0);
    step();
    idle();
    RESET_N = 1'b0;
    #1;
    n_chk++;
    if (out !== '0) begin n_fail++; $display("FAIL rstmid_out: got %0d, required 0", out); end
    n_chk++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid: got %b, required 0", out_valid); end
    exp_q.delete();
    m_acc = 0;
    m_ovf = 1'b0;
    step();
    step();
    RESET_N = 1'b1;
    for (int c = 0; c < 6; c++) begin
      step();
      n_chk++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_stale c=%0d: out_valid=%b out=%0d, required 0", c, out_valid, out); end
    end
    for (int c = 0; c < 6; c++) begin
      if (c == 0) set_beat(fill(2), 1'b1, 1'b0); else idle();
      step();
      n_chk++;
      if (out_valid !== (c == LAT)) begin
        n_fail++; $display("FAIL rstmid_first_valid c=%0d: out_valid=%b, required %b", c, out_valid, c == LAT);
      end
      if (out_valid === 1'b1) begin
        n_chk++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL rstmid_extra: out=%0d with empty scoreboard", out); end
        else begin
          e = exp_q.pop_front();
          if (out !== e.val || ovf !== e.ovf) begin
            n_fail++; $display("FAIL rstmid_first_data: out=%0d ovf=%b, required %0d %b", out, ovf, $signed(e.val), e.ovf);
          end
        end
      end
    end
    n_chk++;
    if (out !== 12'sd16) begin n_fail++; $display("FAIL rstmid_acc_from_zero: out=%0d, required 16", out); end
  endtask

  task automatic test_saturation();
    exp_t           e;
    logic [N*P-1:0] pv [12];
    bit             ae [12];
    bit             ac [12];
    for (int i = 0; i < 12; i++) begin
      ae[i] = 1'b1;
      ac[i] = 1'b0;
    end
    for (int i = 0; i < 5; i++) pv[i] = fill(63);
    pv[5] = fill(1);
    pv[6] = fill(1);
    for (int i = 7; i < 11; i++) pv[i] = fill(-64);
    pv[11] = fill(0);
    ac[0] = 1'b1;
    ac[6] = 1'b1;
    ac[7] = 1'b1;
    ae[11] = 1'b0;
    ac[11] = 1'b1;
    pv[10] = fill(-64);
    begin
      logic [N*P-1:0] extra;
      extra = fill(-64);
      for (int c = 0; c < 12 + 5 + 1; c++) begin
        if (c < 12) set_beat(pv[c], ae[c], ac[c]);
        else if (c == 12) set_beat(extra, 1'b1, 1'b0);
        else idle();
        step();
        n_chk++;
        if (out_valid !== (c >= LAT && c < LAT + 13)) begin
          n_fail++; $display("FAIL sat_valid c=%0d: out_valid=%b, required %b", c, out_valid, c >= LAT && c < LAT + 13);
        end
        if (out_valid === 1'b1) begin
          n_chk++;
          if (exp_q.size() == 0) begin n_fail++; $display("FAIL sat_extra: out=%0d with empty scoreboard", out); end
          else begin
            e = exp_q.pop_front();
            if (out !== e.val || ovf !== e.ovf) begin
              n_fail++; $display("FAIL sat_data c=%0d: out=%0d ovf=%b, required %0d %b", c, out, ovf, $signed(e.val), e.ovf);
            end
          end
        end
      end
    end
    n_chk++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL sat_drain: %0d beats missing, required 0", exp_q.size()); end
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    m_acc  = 0;
    m_ovf  = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_accum();
    test_hold();
    test_reset_mid();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
